decoder_scan: RTL and testbench
===============================

# decoder_scan

Parametrised, registered binary decoder with a valid/ready handshake on both sides. It is the successor to the fixed 3-to-8 combinational decoder. Besides one-hot decoding it supports thermometer decoding and a free-running walking-one scan mode with a programmable step period. It sits between a select-producing controller and one-hot consumers such as row/channel enables and LED or mux strobes.

## Interface
- `SEL_W`, default 3: width of the binary select. `OUT_W = 2**SEL_W` is derived, not overridable.
- `DIV_W`, default 8: width of the scan step-period register.
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  block enable; 0 blocks new input and stops scan
- `mode`  in  2  00 one-hot, 01 thermometer, 10 scan, 11 reserved
- `in_valid`  in  1  `din`/`mode` word offered
- `in_ready`  out  1  word accepted when `in_valid && in_ready`
- `din`  in  SEL_W  binary select
- `scan_div`  in  DIV_W  scan step period minus one
- `dout`  out  OUT_W  registered decoded word
- `out_valid`  out  1  `dout` valid
- `out_ready`  in  1  consumer accepts `dout`
- `wrap`  out  1  one-cycle pulse when scan position wraps from OUT_W-1 to 0
- `err`  out  1  one-cycle pulse when a word is accepted with `mode==11`

## Operation
- States:
  - IDLE: `out_valid=0`.
  - FULL: `out_valid=1`, holding a decoded word.
  - SCAN: walking one.
- `in_ready = en && state!=SCAN && (state==IDLE || out_ready) && mode!=10`. This is combinational.
- Accept (IDLE or FULL, `in_valid && in_ready`): `dout` loads the decoded word, `out_valid=1`, next state FULL. `mode` is sampled at acceptance.
  - 00: `dout[din]=1`, all other bits 0.
  - 01: `dout[din:0]` all 1, upper bits 0. `din=0` gives `...0001`; `din=OUT_W-1` gives all ones.
  - 11: `dout=0`, `out_valid=1`, `err=1` for one cycle.
- FULL with `out_ready` and no accept: next state IDLE, `dout` cleared to 0.
- Entering SCAN requires `en && mode==10`, from IDLE or from FULL once `out_ready` drains the held word.
  - Next cycle: `dout=1<<0`, `out_valid=1`, position 0, divider 0.
- In SCAN:
  - The divider counts up each cycle. When `count >= scan_div`, the divider reloads to 0 and the position advances.
  - `>=` ensures that lowering `scan_div` mid-count does not stall.
  - Advancing from OUT_W-1 wraps to 0 and pulses `wrap` in the same cycle as `dout` becomes `1<<0`.
  - `out_ready` is ignored; scan is a free-running strobe.
- Leaving SCAN: on `!en` or `mode!=10`, the next state is IDLE, with `dout=0` and `out_valid=0`. Position and divider reset to 0.
- `en=0` in FULL: the held word is still drained by `out_ready`; no new accept.
- Reset (async, any state, including mid-scan): `dout=0`, `out_valid=0`, `wrap=0`, `err=0`, state IDLE, position 0, divider 0. Outputs clear immediately on `rst_n` fall.

## Timing
- Accept-to-`out_valid` latency is 1 cycle.
- Throughput is 1 word/cycle while `out_ready=1`, because FULL re-accepts in the same cycle it drains.
- Backpressure: with `out_ready=0` in FULL, `in_ready=0` and `dout` is stable.
- Scan step period is `scan_div+1` cycles. Full sweep is `OUT_W*(scan_div+1)` cycles. `scan_div=0` steps every cycle.
- A `scan_div` change takes effect at the next compare, with no glitch on `dout`.
- `wrap` and `err` are registered, high for exactly one cycle.
- Simultaneous accept and `mode` change: the sampled `mode` governs that word; the new `mode` governs the next.

## Structure
- Shared package `decoder_pkg` contains:
  - `mode_t` enum: ONEHOT, THERMO, SCAN, RSVD.
  - `state_t` enum: IDLE, FULL, SCAN.
  - Pure functions `onehot_f(sel)` and `thermo_f(sel)`, parametrised by SEL_W.
- One sub-module, `scan_tick_gen`: DIV_W counter with `clr`, `scan_div` in, and `tick` out. It is reused by other strobe blocks.
- Target size: 150–250 lines of RTL.

## Test plan
All scenarios use `SEL_W=3`.
- Reset: assert `rst_n=0` mid-scan → `dout=0x00`, `out_valid=0`, `wrap=0` immediately. After release with `en=1`, `mode=00`: `in_ready=1`.
- One-hot with `out_ready=1`, `din` = 0, 5, 7 back-to-back → `dout` = 0x01, 0x20, 0x80 on consecutive cycles, 1-cycle latency, `out_valid` continuous.
- Thermometer, `din` = 0, 3, 7 → `dout` = 0x01, 0x0F, 0xFF.
- Backpressure: `out_ready=0`, offer `din=2` then `din=6` (one-hot).
  - `dout` holds 0x04 and `in_ready=0`.
  - Raise `out_ready` → 0x40 appears the following cycle.
- Scan with `scan_div=2`:
  - Sequence is 0x01×3, 0x02×3, …, 0x80×3, then 0x01 with `wrap=1` in that cycle. Period is 24 cycles.
  - Drop `en` → next cycle `dout=0`, `out_valid=0`.
- Reserved mode: accept with `mode=11`, `din=4` → `dout=0x00`, `out_valid=1`, one-cycle `err` pulse. The next one-hot word decodes normally.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and decode helpers for the decoder_scan family.
// Helpers work at a fixed maximum width; callers zero-extend the select
// and truncate the result to their own 2**SEL_W output width.
package decoder_pkg;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 256;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERMO = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FULL = 2'b01,
        ST_SCAN = 2'b10
    } state_t;

    // One-hot decode: bit sel set, all others clear.
    function automatic logic [MAX_OUT_W-1:0] onehot_f(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_OUT_W-1:0] r;
        r      = '0;
        r[sel] = 1'b1;
        return r;
    endfunction

    // Thermometer decode: bits sel down to 0 set, upper bits clear.
    function automatic logic [MAX_OUT_W-1:0] thermo_f(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            r[i] = (i <= int'(sel));
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Programmable step-period divider. While not cleared it counts up each
// cycle and emits tick once count >= scan_div, reloading to 0 on that tick.
// The >= compare means lowering scan_div mid-count never stalls the strobe.
module scan_tick_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] scan_div,
    output logic             tick
);

    logic [DIV_W-1:0] count_r;

    assign tick = (!clr) && (count_r >= scan_div);

    // Divider counter: hold at zero while cleared, reload on tick, else count up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {DIV_W{1'b0}};
        end else if (clr || tick) begin
            count_r <= {DIV_W{1'b0}};
        end else begin
            count_r <= count_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary decoder with valid/ready on both sides. Supports
// one-hot and thermometer decode of accepted words and a free-running
// walking-one scan whose step period is scan_div+1 cycles.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DIV_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      din,
    input  logic [DIV_W-1:0]      scan_div,
    output logic [(2**SEL_W)-1:0] dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wrap,
    output logic                  err
);

    localparam int OUT_W = 2**SEL_W;

    mode_t            mode_s;
    state_t           state_r, state_nxt_s;
    logic [OUT_W-1:0] dout_r, dout_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    logic             wrap_r, wrap_nxt_s;
    logic             err_r, err_nxt_s;
    logic [SEL_W-1:0] pos_r, pos_nxt_s, pos_adv_s;
    logic [OUT_W-1:0] word_onehot_s, word_thermo_s, word_scan_s, word_first_s;
    logic             in_ready_s, accept_s, scan_entry_s, leave_scan_s;
    logic             div_clr_s, tick_s;

    assign mode_s       = mode_t'(mode);
    assign in_ready_s   = en && (state_r != ST_SCAN) &&
                          ((state_r == ST_IDLE) || out_ready) && (mode_s != MODE_SCAN);
    assign accept_s     = in_valid && in_ready_s;
    // A held word must be drained before the scan may take over the output.
    assign scan_entry_s = en && (mode_s == MODE_SCAN) &&
                          ((state_r == ST_IDLE) || ((state_r == ST_FULL) && out_ready));
    assign leave_scan_s = (!en) || (mode_s != MODE_SCAN);
    assign pos_adv_s    = pos_r + {{(SEL_W-1){1'b0}}, 1'b1};
    assign word_first_s = {{(OUT_W-1){1'b0}}, 1'b1};
    // Divider only runs while the scan is active and not about to stop.
    assign div_clr_s    = (state_r != ST_SCAN) || leave_scan_s;

    scan_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (div_clr_s),
        .scan_div (scan_div),
        .tick     (tick_s)
    );

    // Candidate output words for each decode source.
    always_comb begin
        word_onehot_s = OUT_W'(onehot_f(MAX_SEL_W'(din)));
        word_thermo_s = OUT_W'(thermo_f(MAX_SEL_W'(din)));
        word_scan_s   = OUT_W'(onehot_f(MAX_SEL_W'(pos_adv_s)));
    end

    // Next-state and next-output logic for the IDLE/FULL/SCAN controller.
    always_comb begin
        state_nxt_s     = state_r;
        dout_nxt_s      = dout_r;
        out_valid_nxt_s = out_valid_r;
        pos_nxt_s       = pos_r;
        wrap_nxt_s      = 1'b0;
        err_nxt_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_FULL: begin
                if (accept_s) begin
                    state_nxt_s     = ST_FULL;
                    out_valid_nxt_s = 1'b1;
                    err_nxt_s       = (mode_s == MODE_RSVD);
                    case (mode_s)
                        MODE_ONEHOT: dout_nxt_s = word_onehot_s;
                        MODE_THERMO: dout_nxt_s = word_thermo_s;
                        default:     dout_nxt_s = {OUT_W{1'b0}};
                    endcase
                end else if (scan_entry_s) begin
                    state_nxt_s     = ST_SCAN;
                    dout_nxt_s      = word_first_s;
                    out_valid_nxt_s = 1'b1;
                    pos_nxt_s       = {SEL_W{1'b0}};
                end else if ((state_r == ST_FULL) && out_ready) begin
                    state_nxt_s     = ST_IDLE;
                    dout_nxt_s      = {OUT_W{1'b0}};
                    out_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SCAN: begin
                if (leave_scan_s) begin
                    state_nxt_s     = ST_IDLE;
                    dout_nxt_s      = {OUT_W{1'b0}};
                    out_valid_nxt_s = 1'b0;
                    pos_nxt_s       = {SEL_W{1'b0}};
                end else if (tick_s) begin
                    pos_nxt_s  = pos_adv_s;
                    dout_nxt_s = word_scan_s;
                    wrap_nxt_s = &pos_r;
                end else begin
                    pos_nxt_s = pos_r;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                dout_nxt_s      = {OUT_W{1'b0}};
                out_valid_nxt_s = 1'b0;
                pos_nxt_s       = {SEL_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            dout_r      <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            wrap_r      <= 1'b0;
            err_r       <= 1'b0;
            pos_r       <= {SEL_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            dout_r      <= dout_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            wrap_r      <= wrap_nxt_s;
            err_r       <= err_nxt_s;
            pos_r       <= pos_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign dout      = dout_r;
    assign out_valid = out_valid_r;
    assign wrap      = wrap_r;
    assign err       = err_r;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan (SEL_W=3): directed scenarios
// followed by randomized handshake traffic against a transaction model.
module tb_decoder_scan;

    localparam int SEL_W = 3;
    localparam int DIV_W = 8;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] din;
    logic [DIV_W-1:0] scan_div;
    logic [OUT_W-1:0] dout;
    logic             out_valid;
    logic             out_ready;
    logic             wrap;
    logic             err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .scan_div  (scan_div),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wrap      (wrap),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode straight from the mode rules.
    function automatic int ref_word(input int m, input int sel);
        case (m)
            0:       return 1 << sel;
            1:       return (1 << (sel + 1)) - 1;
            default: return 0;
        endcase
    endfunction

    int  exp_ready, m_valid, m_word, m_err, r;
    bit  acc;

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; in_valid = 1'b0;
        din = 3'd0; scan_div = 8'd0; out_ready = 1'b0;
        #12;
        chk("rst_dout", dout, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1; en = 1'b1; mode = 2'b00;
        #1;
        chk("rel_in_ready", in_ready, 1);
        step();

        // One-hot back-to-back, 1-cycle latency, continuous valid
        out_ready = 1'b1; in_valid = 1'b1;
        din = 3'd0; step(); chk("oh0", dout, 8'h01); chk("oh0_v", out_valid, 1);
        din = 3'd5; step(); chk("oh5", dout, 8'h20); chk("oh5_v", out_valid, 1);
        din = 3'd7; step(); chk("oh7", dout, 8'h80); chk("oh7_v", out_valid, 1);
        in_valid = 1'b0; step();
        chk("oh_drain_v", out_valid, 0); chk("oh_drain_d", dout, 0);

        // Thermometer
        mode = 2'b01; in_valid = 1'b1;
        din = 3'd0; step(); chk("th0", dout, 8'h01);
        din = 3'd3; step(); chk("th3", dout, 8'h0F);
        din = 3'd7; step(); chk("th7", dout, 8'hFF);
        in_valid = 1'b0; step(); chk("th_drain_v", out_valid, 0);

        // Backpressure
        mode = 2'b00; out_ready = 1'b0; in_valid = 1'b1; din = 3'd2;
        step(); chk("bp_first", dout, 8'h04); chk("bp_first_v", out_valid, 1);
        din = 3'd6; #1; chk("bp_in_ready", in_ready, 0);
        step(); chk("bp_hold1", dout, 8'h04);
        step(); chk("bp_hold2", dout, 8'h04); chk("bp_in_ready2", in_ready, 0);
        out_ready = 1'b1; #1; chk("bp_release_ready", in_ready, 1);
        step(); chk("bp_second", dout, 8'h40); chk("bp_second_v", out_valid, 1);
        in_valid = 1'b0; step(); chk("bp_drain_v", out_valid, 0);

        // Reserved mode
        mode = 2'b11; din = 3'd4; in_valid = 1'b1;
        step(); chk("rsv_dout", dout, 0); chk("rsv_v", out_valid, 1); chk("rsv_err", err, 1);
        mode = 2'b00; din = 3'd4;
        step(); chk("rsv_next", dout, 8'h10); chk("rsv_err_clr", err, 0);
        in_valid = 1'b0; step(); chk("rsv_drain_v", out_valid, 0);

        // Scan, scan_div=2: each position held 3 cycles, wrap after 24
        mode = 2'b10; scan_div = 8'd2; #1; chk("scan_in_ready", in_ready, 0);
        step(); chk("scan_k0", dout, 8'h01); chk("scan_k0_v", out_valid, 1); chk("scan_k0_w", wrap, 0);
        for (int k = 1; k <= 26; k++) begin
            step();
            chk("scan2_dout", dout, 1 << ((k / 3) % 8));
            chk("scan2_wrap", wrap, (k == 24) ? 1 : 0);
            chk("scan2_v", out_valid, 1);
        end
        en = 1'b0; step(); chk("scan_off_d", dout, 0); chk("scan_off_v", out_valid, 0);

        // Scan, scan_div=0: steps every cycle
        en = 1'b1; scan_div = 8'd0;
        step(); chk("scan0_k0", dout, 8'h01);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("scan0_dout", dout, 1 << (k % 8));
            chk("scan0_wrap", wrap, (k == 8) ? 1 : 0);
        end
        mode = 2'b00; step(); chk("scan0_off_v", out_valid, 0);

        // Lowering scan_div mid-count takes effect at the next compare
        mode = 2'b10; scan_div = 8'd7;
        step(); chk("div_k0", dout, 8'h01);
        step(); chk("div_k1", dout, 8'h01);
        step(); chk("div_k2", dout, 8'h01);
        scan_div = 8'd1;
        step(); chk("div_k3", dout, 8'h02);
        step(); chk("div_k4", dout, 8'h02);
        step(); chk("div_k5", dout, 8'h04);

        // Asynchronous reset mid-scan
        #2; rst_n = 1'b0; #1;
        chk("arst_dout", dout, 0); chk("arst_valid", out_valid, 0); chk("arst_wrap", wrap, 0);
        mode = 2'b00; en = 1'b1;
        step();
        rst_n = 1'b1; #1;
        chk("arst_in_ready", in_ready, 1);
        step();
        chk("arst_idle_v", out_valid, 0);

        // Randomized handshake traffic (no scan) vs transaction model
        m_valid = 0; m_word = 0; m_err = 0;
        for (int i = 0; i < 300; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            r         = $urandom_range(0, 2);
            mode      = (r == 2) ? 2'b11 : 2'(r);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            din       = 3'($urandom_range(0, 7));
            #1;
            exp_ready = (en && (m_valid == 0 || out_ready)) ? 1 : 0;
            chk("rnd_in_ready", in_ready, exp_ready);
            acc = in_valid && (exp_ready != 0);
            if (acc) begin
                m_word  = ref_word(int'(mode), int'(din));
                m_valid = 1;
                m_err   = (mode == 2'b11) ? 1 : 0;
            end else begin
                m_err = 0;
                if (m_valid != 0 && out_ready) begin
                    m_valid = 0;
                    m_word  = 0;
                end
            end
            step();
            chk("rnd_dout", dout, m_word);
            chk("rnd_valid", out_valid, m_valid);
            chk("rnd_err", err, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
